duty_ramp_ctrl: RTL and testbench
=================================

# duty_ramp_ctrl

Soft-start/slew controller sitting directly upstream of `pwm_generator`. Accepts a target duty over a valid/ready handshake and moves its `duty` output toward that target by a fixed step. It updates only at PWM period boundaries, detected from the generator's `counter`, so `pwmout` never sees a mid-period duty change. Reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 8: duty/counter width; matches `pwm_generator`.
- `STEP`, 1: duty increment/decrement per step; range 1..2^WIDTH-1.
- `PERIODS_PER_STEP`, 1: PWM periods between steps; minimum 1.
- `MAX_DUTY`, 230: upper target limit; used only with `DUTY_RAMP_LIMIT_EN`.
- `clk`  in  1: the single clock, shared with `pwm_generator`.
- `rst_n`  in  1: asynchronous, active-low reset.
- `counter`  in  WIDTH: free-running period counter from `pwm_generator`.
- `target`  in  WIDTH: requested duty.
- `target_valid`  in  1: `target` is valid.
- `target_ready`  out  1: controller can accept a target.
- `duty`  out  WIDTH: registered duty; drives `pwm_generator.duty`.
- `busy`  out  1: ramp in progress.
- `done`  out  1: one-cycle pulse when `duty` reaches the accepted target.

## Operation
- States:
  - IDLE: `target_ready`=1, `busy`=0.
  - RAMP_UP and RAMP_DOWN: `target_ready`=0, `busy`=1.
- Accept: a target is accepted on a `clk` edge with `target_valid && target_ready`, and latched into `tgt_q`.
  - `tgt_q` > `duty`: go to RAMP_UP.
  - `tgt_q` < `duty`: go to RAMP_DOWN.
  - `tgt_q` == `duty`: stay in IDLE and pulse `done` on the next cycle.
- Period tick: `tick` is asserted when `counter` == all-ones. A tick counter counts ticks modulo `PERIODS_PER_STEP`. A step fires on the tick that completes a group. The tick counter clears on accept.
- RAMP_UP step: `duty <= min(duty + STEP, tgt_q)`. Computed in WIDTH+1 bits, so there is no wrap past 2^WIDTH-1.
- RAMP_DOWN step: `duty <= (duty < tgt_q + STEP) ? tgt_q : duty - STEP`. Computed in WIDTH+1 bits, so there is no underflow below 0.
- Completion: when a step writes `duty == tgt_q`, the FSM returns to IDLE and `done` pulses for exactly one cycle, on the cycle after the final write.
- `target_valid` while not ready: the target is ignored, not queued. The upstream holds `target_valid` until the handshake completes.
- `target` values are unconstrained. 0 and 2^WIDTH-1 are legal.

## Timing
- Reset (asynchronous, while `rst_n`=0): `duty`=0, state IDLE, `tgt_q`=0, tick counter=0, `done`=0, `busy`=0, `target_ready`=1.
- `target_ready` and `busy` are decoded directly from the state register (no extra latency).
- Accept at edge N: `busy`=1 after edge N. The first step fires at the first qualifying tick strictly after edge N.
- Step timing: `duty` changes on the edge where `counter` goes from all-ones to 0. The new value applies from `counter`=0 of the next period.
- Ramp duration: ceil(|target − start| / STEP) × `PERIODS_PER_STEP` periods, with a period of 2^WIDTH clocks.
- Simultaneous events:
  - A tick on the same edge as accept does not step.
  - A `done` cycle in IDLE may also accept a new target.
- Reset mid-ramp: `duty` drops to 0 immediately, with no ramp-down, and no `done` is issued.

## Configuration
- `DUTY_RAMP_LIMIT_EN` defined: an accepted target above `MAX_DUTY` is clamped, so `tgt_q = MAX_DUTY`, and `done` fires at `MAX_DUTY`.
- `DUTY_RAMP_LIMIT_EN` undefined: the target is latched unmodified and `MAX_DUTY` is unused.

## Structure
- Shared package `pwm_pkg` holds:
  - `PWM_WIDTH` (8), the default width.
  - `duty_ramp_state_t`, the enum IDLE/RAMP_UP/RAMP_DOWN.
- Sub-module `pwm_period_tick` contains the all-ones detect plus the `PERIODS_PER_STEP` counter with synchronous clear. Its output is a single-cycle `step_en`.
- Everything else, meaning the FSM, step arithmetic and handshake, lives in `duty_ramp_ctrl`.

## Test plan
Parameters for all scenarios: `STEP`=10, `PERIODS_PER_STEP`=1, `WIDTH`=8, with `counter` driven by a real `pwm_generator` instance.

- Reset: assert `rst_n`=0 mid-simulation → `duty`=0, `busy`=0, `target_ready`=1, `done`=0 asynchronously.
- Ramp up: from `duty`=0, accept `target`=45 → `duty` goes 10,20,30,40,45 at successive counter wraps; `done` pulses once after 45; `target_ready` is 0 throughout.
- Ramp down and equal: accept `target`=5 from 45 → `duty` goes 35,25,15,5, then `done`. Then accept `target`=5 again → `done` next cycle, `busy` stays 0, `duty` is unchanged.
- Boundaries: accept `target`=255 from 250 → `duty`=255 without wrap. Accept `target`=0 from 3 → `duty`=0 without underflow.
- Handshake and reset: hold `target_valid`=1 with `target`=90 during a ramp → not accepted until IDLE, then accepted. Pulse `rst_n`=0 mid-ramp → `duty`=0, no `done`.
- With `DUTY_RAMP_LIMIT_EN` and `MAX_DUTY`=230: accept `target`=250 → ramp stops at 230 and `done` pulses.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: the default duty/counter width and the ramp FSM state type.
package pwm_pkg;

   localparam int PWM_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } duty_ramp_state_t;

endpackage

// File: rtl/duty_ramp_ctrl_if.sv
// Target handshake between the upstream requester (master) and duty_ramp_ctrl (slave).
interface duty_ramp_if
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
);
   logic [WIDTH-1:0] target;
   logic             target_valid;
   logic             target_ready;

   modport master (output target, output target_valid, input  target_ready);
   modport slave  (input  target, input  target_valid, output target_ready);
endinterface

// File: rtl/duty_ramp_ctrl_period_tick.sv
// Period boundary detector: counter all-ones marks the last clock of a PWM
// period; every PERIODS_PER_STEP-th such tick raises step_en_o for one cycle.
// clr_i restarts the grouping (used on target accept).
module pwm_period_tick #(
   parameter int WIDTH            = 8,
   parameter int PERIODS_PER_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] counter_i,
   output logic             step_en_o
);
   localparam int           CW   = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIODS_PER_STEP - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick_s;

   assign tick_s = &counter_i;

   // Tick group counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Advance the group counter on each tick, wrapping after the last tick of a group.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CW{1'b0}};
      end else if (tick_s) begin
         if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign step_en_o = tick_s && (cnt_q == LAST) && !clr_i;
endmodule

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: soft-start / slew limiter in front of pwm_generator.
// Accepts a target duty, then steps duty by STEP toward it only at PWM period
// boundaries, pulsing done one cycle after the final write.
// Optional build macro: DUTY_RAMP_LIMIT_EN clamps accepted targets to MAX_DUTY.
module duty_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH            = PWM_WIDTH,
   parameter int STEP             = 1,
   parameter int PERIODS_PER_STEP = 1,
   parameter int MAX_DUTY         = 230
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] counter,
   duty_ramp_if.slave       tgt_if,
   output logic [WIDTH-1:0] duty,
   output logic             busy,
   output logic             done
);
   localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

   if ((STEP < 1) || (STEP > (2 ** WIDTH) - 1)) begin : g_bad_step
      $error("duty_ramp_ctrl: STEP out of range");
   end
   if (PERIODS_PER_STEP < 1) begin : g_bad_pps
      $error("duty_ramp_ctrl: PERIODS_PER_STEP must be at least 1");
   end
   if ((MAX_DUTY < 0) || (MAX_DUTY > (2 ** WIDTH) - 1)) begin : g_bad_max
      $error("duty_ramp_ctrl: MAX_DUTY out of range");
   end

   duty_ramp_state_t state_q, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             done_q, done_d;

   logic             ready_s;
   logic             busy_s;
   logic             accept_s;
   logic             step_en_s;
   logic [WIDTH-1:0] tgt_in_s;
   logic [WIDTH:0]   sum_up_s;
   logic [WIDTH:0]   thr_dn_s;
   logic [WIDTH-1:0] up_nxt_s;
   logic [WIDTH-1:0] dn_nxt_s;

   assign accept_s = tgt_if.target_valid && ready_s;

`ifdef DUTY_RAMP_LIMIT_EN
   localparam logic [WIDTH-1:0] MAX_T = WIDTH'(MAX_DUTY);
   assign tgt_in_s = (tgt_if.target > MAX_T) ? MAX_T : tgt_if.target;
`else
   assign tgt_in_s = tgt_if.target;
`endif

   // Step arithmetic carries one extra bit so neither direction can wrap.
   assign sum_up_s = {1'b0, duty_q} + STEP_X;
   assign up_nxt_s = (sum_up_s > {1'b0, tgt_q}) ? tgt_q : sum_up_s[WIDTH-1:0];
   assign thr_dn_s = {1'b0, tgt_q} + STEP_X;
   assign dn_nxt_s = ({1'b0, duty_q} < thr_dn_s) ? tgt_q : (duty_q - STEP_X[WIDTH-1:0]);

   pwm_period_tick #(
      .WIDTH            (WIDTH),
      .PERIODS_PER_STEP (PERIODS_PER_STEP)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (accept_s),
      .counter_i (counter),
      .step_en_o (step_en_s)
   );

   // State, latched target, duty and done registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tgt_q   <= {WIDTH{1'b0}};
         duty_q  <= {WIDTH{1'b0}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         done_q  <= done_d;
      end
   end

   // Next state: accept in IDLE, step toward the target on step_en while ramping.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      duty_d  = duty_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               tgt_d = tgt_in_s;
               if (tgt_in_s > duty_q) begin
                  state_d = RAMP_UP;
               end else if (tgt_in_s < duty_q) begin
                  state_d = RAMP_DOWN;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RAMP_UP: begin
            if (step_en_s) begin
               duty_d = up_nxt_s;
               if (up_nxt_s == tgt_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RAMP_UP;
               end
            end else begin
               state_d = RAMP_UP;
            end
         end
         RAMP_DOWN: begin
            if (step_en_s) begin
               duty_d = dn_nxt_s;
               if (dn_nxt_s == tgt_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RAMP_DOWN;
               end
            end else begin
               state_d = RAMP_DOWN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and busy decoded straight from the state register.
   always_comb begin
      ready_s = 1'b0;
      busy_s  = 1'b0;
      if (state_q == IDLE) begin
         ready_s = 1'b1;
         busy_s  = 1'b0;
      end else begin
         ready_s = 1'b0;
         busy_s  = 1'b1;
      end
   end

   assign tgt_if.target_ready = ready_s;
   assign busy                = busy_s;
   assign duty                = duty_q;
   assign done                = done_q;
endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Self-checking bench for duty_ramp_ctrl (STEP=10, PERIODS_PER_STEP=1, WIDTH=8).
// Expected trajectories come from the slew rule: start moved by k*STEP toward
// the target, clipped at the target, one value per PWM period.
module tb_duty_ramp_ctrl;
   import pwm_pkg::*;

   localparam int W    = 8;
   localparam int STEP = 10;
   localparam int PPS  = 1;
   localparam int MAXD = 230;
   localparam int PER  = 256;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic [W-1:0] counter = '0;
   logic [W-1:0] duty;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_bad = 0;
   int cur   = 0;

   typedef struct {
      int target;
      int final_duty;
      int nsteps;
   } vec_t;

   vec_t tbl [7];

   duty_ramp_if #(.WIDTH(W)) tif ();

   duty_ramp_ctrl #(
      .WIDTH            (W),
      .STEP             (STEP),
      .PERIODS_PER_STEP (PPS),
      .MAX_DUTY         (MAXD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .counter (counter),
      .tgt_if  (tif.slave),
      .duty    (duty),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Free-running PWM period counter, as pwm_generator would provide.
   always @(posedge clk) counter <= counter + 8'd1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int eff_target(input int t);
`ifdef DUTY_RAMP_LIMIT_EN
      return (t > MAXD) ? MAXD : t;
`else
      return t;
`endif
   endfunction

   // Present a target at a negedge; optionally wait until counter is all-ones
   // so the accept edge coincides with a period tick. Returns the counter value
   // seen on the accept edge.
   task automatic accept(input int t, input bit align, output int c_acc);
      @(negedge clk);
      if (align) begin
         for (int j = 0; j < 300 && counter != 8'hFF; j++) @(negedge clk);
      end
      chk("ready_idle", int'(tif.target_ready), 1);
      tif.target       = W'(t);
      tif.target_valid = 1'b1;
      c_acc            = int'(counter);
      @(posedge clk);
      #1 tif.target_valid = 1'b0;
   endtask

   // Follow one ramp from start to tgt, beginning at the first negedge after
   // the accept edge (cyc0 = negedges already consumed since that edge).
   task automatic watch(input int start, input int tgt, input int c_acc,
                        input int cyc0, output int steps);
      int q[$];
      int v, prev, cyc, first_cyc, k_first, budget;
      bit got_done, hold_bad;
      steps = 0;
      for (int k = 1; k <= PER; k++) begin
         if (tgt > start) begin
            v = start + k * STEP;
            if (v >= tgt) begin q.push_back(tgt); break; end
            q.push_back(v);
         end else if (tgt < start) begin
            v = start - k * STEP;
            if (v <= tgt) begin q.push_back(tgt); break; end
            q.push_back(v);
         end else begin
            break;
         end
      end
      if (q.size() == 0) begin
         @(negedge clk);
         chk("eq_done", int'(done), 1);
         chk("eq_busy", int'(busy), 0);
         chk("eq_duty", int'(duty), start);
         @(negedge clk);
         chk("done_single", int'(done), 0);
         return;
      end
      k_first = (PER - c_acc) % PER;
      if (k_first < 2) k_first += PER;
      budget    = (q.size() + 1) * PER * PPS + 4;
      prev      = start;
      cyc       = cyc0;
      first_cyc = -1;
      got_done  = 1'b0;
      hold_bad  = 1'b0;
      while (cyc < budget && !got_done) begin
         @(negedge clk);
         cyc++;
         if (int'(duty) != prev) begin
            steps++;
            if (first_cyc < 0) first_cyc = cyc;
            if (q.size() > 0) begin
               chk("step_value", int'(duty), q[0]);
               void'(q.pop_front());
            end else begin
               chk("step_unexpected", int'(duty), prev);
            end
            chk("step_at_wrap", int'(counter), 0);
            prev = int'(duty);
         end
         if (done) begin
            got_done = 1'b1;
            chk("done_after_final", q.size(), 0);
            chk("idle_busy_at_done", int'(busy), 0);
            chk("idle_ready_at_done", int'(tif.target_ready), 1);
         end else if (busy !== 1'b1 || tif.target_ready !== 1'b0) begin
            hold_bad = 1'b1;
         end
      end
      chk("done_seen", int'(got_done), 1);
      chk("busy_during_ramp", int'(hold_bad), 0);
      chk("first_step_delay", first_cyc, k_first);
      chk("final_duty", int'(duty), tgt);
      @(negedge clk);
      chk("done_single", int'(done), 0);
   endtask

   // Global time bound.
   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c, steps, t, t1, bad;

      tbl[0] = '{45, 45, 5};
      tbl[1] = '{5, 5, 4};
      tbl[2] = '{5, 5, 0};
`ifdef DUTY_RAMP_LIMIT_EN
      tbl[3] = '{250, 230, 23};
      tbl[4] = '{255, 230, 0};
      tbl[5] = '{3, 3, 23};
`else
      tbl[3] = '{250, 250, 25};
      tbl[4] = '{255, 255, 1};
      tbl[5] = '{3, 3, 26};
`endif
      tbl[6] = '{0, 0, 1};

      tif.target       = '0;
      tif.target_valid = 1'b0;
      rst_n            = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_duty", int'(duty), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(tif.target_ready), 1);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      cur   = 0;

      // Directed vectors; vector 1 lands its accept on a period tick.
      for (int i = 0; i < 7; i++) begin
         accept(tbl[i].target, (i == 1), c);
         watch(cur, eff_target(tbl[i].target), c, 0, steps);
         chk("table_steps", steps, tbl[i].nsteps);
         chk("table_final", int'(duty), tbl[i].final_duty);
         cur = eff_target(tbl[i].target);
      end

      // Random targets near the current duty, random accept phase.
      for (int i = 0; i < 6; i++) begin
         t = cur + int'($urandom_range(0, 160)) - 80;
         if (t < 0)   t = 0;
         if (t > 255) t = 255;
         repeat ($urandom_range(0, 255)) @(negedge clk);
         accept(t, 1'b0, c);
         watch(cur, eff_target(t), c, 0, steps);
         cur = eff_target(t);
      end

      // Target 90 held valid during a ramp: ignored until the done cycle.
      t1 = (cur < 128) ? cur + 37 : cur - 37;
      if (t1 == 90) t1 = 95;
      accept(t1, 1'b0, c);
      @(negedge clk);
      tif.target       = 8'd90;
      tif.target_valid = 1'b1;
      bad = 0;
      for (int j = 0; j < 6 * PER && !done; j++) begin
         if (tif.target_ready !== 1'b0) bad = 1;
         @(negedge clk);
      end
      chk("hold_ready_low", bad, 0);
      chk("hold_done_seen", int'(done), 1);
      chk("hold_first_duty", int'(duty), t1);
      chk("hold_ready_at_done", int'(tif.target_ready), 1);
      c = int'(counter);
      @(negedge clk);
      tif.target_valid = 1'b0;
      chk("hold_accepted", int'(busy), 1);
      watch(t1, 90, c, 1, steps);
      cur = 90;

      // Reset in the middle of a ramp.
      accept(200, 1'b0, c);
      repeat (300) @(negedge clk);
      chk("ramp_before_reset", int'(busy && duty > 8'd90), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_duty", int'(duty), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(tif.target_ready), 1);
      chk("mid_rst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int j = 0; j < 2 * PER; j++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || duty !== 8'd0) bad = 1;
      end
      chk("post_rst_quiet", bad, 0);
      cur = 0;

      // Recovery ramp after reset.
      accept(20, 1'b0, c);
      watch(cur, 20, c, 0, steps);
      chk("recover_steps", steps, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
